// File: rtl/seg_scan_if.sv
// Bundle of the display-side and consumer-side signals of seg_scan_decoder.
// The master side drives the segment/strobe lines and the consumer ready;
// the slave side (the decoder) returns the captured frame and status.
`timescale 1ns/1ps

interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);

  logic [6:0]              segment;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [NUM_DIGITS-1:0]   err;
  logic                    valid;
  logic                    ready;
  logic                    overrun;

  modport master (
    output segment,
    output dig_en,
    output ready,
    input  bcd,
    input  err,
    input  valid,
    input  overrun
  );

  modport slave (
    input  segment,
    input  dig_en,
    input  ready,
    output bcd,
    output err,
    output valid,
    output overrun
  );

endinterface

// File: rtl/seg_scan_decoder.sv
// Multiplexed seven-segment bus decoder.
// Samples the segment lines and one-hot digit strobes, waits for each digit
// to be stable, captures it into a per-digit slot, and once every digit of a
// scan frame has been seen presents the packed BCD frame on a valid/ready
// handshake. A frame that completes while the previous one is still unread
// is dropped and flagged with a one-cycle overrun pulse.
`timescale 1ns/1ps

module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic     clk,
  input  logic     rst,
  seg_scan_if.slave bus
);

  localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Result of looking up one segment pattern.
  typedef struct packed {
    logic       err;
    logic [3:0] nibble;
  } glyph_t;

  // Segment pattern (bit0=a .. bit6=g) to BCD; anything else is illegal.
  function automatic glyph_t decode(input logic [6:0] seg);
    glyph_t g;
    g.err = 1'b0;
    case (seg)
      7'b0111111: g.nibble = 4'd0;
      7'b0000110: g.nibble = 4'd1;
      7'b1011011: g.nibble = 4'd2;
      7'b1001111: g.nibble = 4'd3;
      7'b1100110: g.nibble = 4'd4;
      7'b1101101: g.nibble = 4'd5;
      7'b1111101: g.nibble = 4'd6;
      7'b0000111: g.nibble = 4'd7;
      7'b1111111: g.nibble = 4'd8;
      7'b1101111: g.nibble = 4'd9;
      default: begin
        g.nibble = 4'hF;
        g.err    = 1'b1;
      end
    endcase
    return g;
  endfunction

  // Input stage and stability tracking.
  logic [6:0]            s_seg;
  logic [NUM_DIGITS-1:0] s_dig;
  logic [CNT_W-1:0]      cnt;

  // Partially assembled frame.
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] slot_bcd;
  logic [NUM_DIGITS-1:0]   slot_err;

  // Presented frame and status.
  logic [4*NUM_DIGITS-1:0] shown_bcd;
  logic [NUM_DIGITS-1:0]   shown_err;
  logic                    frame_valid;
  logic                    drop_pulse;

  // Decision signals.
  logic                    sample_same;
  logic                    next_onehot;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   cap_bit;
  logic                    frame_done;
  glyph_t                  cur_glyph;
  logic [4*NUM_DIGITS-1:0] frame_bcd;
  logic [NUM_DIGITS-1:0]   frame_err;

  // The sample arriving on this edge is compared with the one already held,
  // so the counter reaching STABLE_CYCLES means STABLE_CYCLES+1 identical
  // input cycles. Capture fires only on the step into STABLE_CYCLES, which
  // also makes a saturated counter unable to capture again.
  assign sample_same = ({bus.dig_en, bus.segment} == {s_dig, s_seg});
  assign next_onehot = $onehot(bus.dig_en);
  assign capture     = $onehot(s_dig) && sample_same && (cnt == CNT_LAST);
  assign cap_bit     = capture ? s_dig : '0;
  assign frame_done  = capture && ((mask | cap_bit) == '1);
  assign cur_glyph   = decode(s_seg);

  // Frame contents including the slot being captured on this edge.
  // NOTE: every always_comb output gets a default before any conditional
  // write, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    frame_bcd = slot_bcd;
    frame_err = slot_err;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (cap_bit[k]) begin
        frame_bcd[4*k +: 4] = cur_glyph.nibble;
        frame_err[k]        = cur_glyph.err;
      end
    end
  end

  // Register the bus and count how long the current sample has been stable.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg <= '0;
      s_dig <= '0;
      cnt   <= '0;
    end else begin
      s_seg <= bus.segment;
      s_dig <= bus.dig_en;
      if (!sample_same || !next_onehot) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Assemble digits into slots and hand complete frames to the consumer.
  // NOTE: the slot storage is reset along with the flags; it is only a few
  // flops, and it keeps bcd/err deterministic for any reset-to-frame path.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask        <= '0;
      slot_bcd    <= '0;
      slot_err    <= '0;
      shown_bcd   <= '0;
      shown_err   <= '0;
      frame_valid <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;

      // Accept retires the frame unless a new one loads below.
      if (frame_valid && bus.ready) begin
        frame_valid <= 1'b0;
      end

      if (capture) begin
        slot_bcd <= frame_bcd;
        slot_err <= frame_err;
        if (frame_done) begin
          mask <= '0;
          if (!frame_valid || bus.ready) begin
            shown_bcd   <= frame_bcd;
            shown_err   <= frame_err;
            frame_valid <= 1'b1;
          end else begin
            drop_pulse  <= 1'b1;
          end
        end else begin
          mask <= mask | cap_bit;
        end
      end
    end
  end

  assign bus.bcd     = shown_bcd;
  assign bus.err     = shown_err;
  assign bus.valid   = frame_valid;
  assign bus.overrun = drop_pulse;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios with fixed
// expectations plus a randomized strobe stream, all compared cycle by cycle
// against a run-length based reference model of the decoder.
`timescale 1ns/1ps

module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 3;

  localparam logic [6:0] GLYPH [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_decoder #(
    .NUM_DIGITS   (ND),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counts how many consecutive cycles the same
  // {dig_en,segment} word has been on the bus and captures on the cycle that
  // count reaches SC+1 while the strobe is one-hot.
  int                 run;
  logic [ND+6:0]      last;
  logic [3:0]         m_slot  [ND];
  logic               m_eslot [ND];
  logic [ND-1:0]      m_mask;
  logic [4*ND-1:0]    m_bcd;
  logic [ND-1:0]      m_err;
  logic               m_valid;
  logic               m_ovr;

  task automatic model_step(input logic r, input logic [ND-1:0] d,
                            input logic [6:0] s, input logic rd);
    int   k;
    logic capture;
    logic load_ok;
    if (r) begin
      run = 0; last = '0; m_mask = '0; m_bcd = '0; m_err = '0;
      m_valid = 1'b0; m_ovr = 1'b0;
      for (int i = 0; i < ND; i++) begin
        m_slot[i] = '0; m_eslot[i] = 1'b0;
      end
      return;
    end
    if (run > 0 && {d, s} == last) run++;
    else run = 1;
    last    = {d, s};
    capture = ($countones(d) == 1) && (run == SC + 1);
    load_ok = !m_valid || rd;
    if (m_valid && rd) m_valid = 1'b0;
    m_ovr = 1'b0;
    if (capture) begin
      k = 0;
      for (int i = 0; i < ND; i++) if (d[i]) k = i;
      m_slot[k]  = 4'hF;
      m_eslot[k] = 1'b1;
      for (int g = 0; g < 10; g++) begin
        if (GLYPH[g] == s) begin
          m_slot[k]  = 4'(g);
          m_eslot[k] = 1'b0;
        end
      end
      m_mask[k] = 1'b1;
      if (m_mask == '1) begin
        m_mask = '0;
        if (load_ok) begin
          for (int j = 0; j < ND; j++) begin
            m_bcd[4*j +: 4] = m_slot[j];
            m_err[j]        = m_eslot[j];
          end
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive inputs, step the model at the edge, settle past it.
  task automatic tick(input logic [ND-1:0] d, input logic [6:0] s,
                      input logic rd, input logic r);
    bus.dig_en  = d;
    bus.segment = s;
    bus.ready   = rd;
    rst         = r;
    @(posedge clk);
    model_step(r, d, s, rd);
    #1;
  endtask

  // Present one bus word for n cycles, comparing the DUT with the model
  // after every edge.
  task automatic hold(input string tag, input logic [ND-1:0] d,
                      input logic [6:0] s, input logic rd, input int n);
    for (int i = 0; i < n; i++) begin
      tick(d, s, rd, 1'b0);
      n_tests++;
      if ({bus.valid, bus.overrun, bus.err, bus.bcd} !==
          {m_valid, m_ovr, m_err, m_bcd}) begin
        n_fail++;
        $display("FAIL %s cyc%0d: dut v=%b ov=%b err=%b bcd=%h, model v=%b ov=%b err=%b bcd=%h",
                 tag, i, bus.valid, bus.overrun, bus.err, bus.bcd,
                 m_valid, m_ovr, m_err, m_bcd);
      end
    end
  endtask

  function automatic logic [ND-1:0] dsel(input int k);
    logic [ND-1:0] d;
    d    = '0;
    d[k] = 1'b1;
    return d;
  endfunction

  function automatic logic [4*ND-1:0] rand_vals();
    logic [4*ND-1:0] v;
    for (int k = 0; k < ND; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Send digits lo..hi of a frame, each held six cycles.
  task automatic send_digits(input string tag, input logic [4*ND-1:0] vals,
                             input int lo, input int hi, input logic rd);
    for (int k = lo; k <= hi; k++) hold(tag, dsel(k), GLYPH[vals[4*k +: 4]], rd, 6);
  endtask

  task automatic test_reset();
    tick('0, '0, 1'b0, 1'b1);
    tick('0, '0, 1'b0, 1'b1);
    n_tests++;
    if ({bus.valid, bus.overrun, bus.err, bus.bcd} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b ov=%b err=%b bcd=%h, want all zero",
               bus.valid, bus.overrun, bus.err, bus.bcd);
    end
    tick('0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_single_frame();
    send_digits("single", 16'h3210, 0, 2, 1'b0);
    hold("single_d3", dsel(3), GLYPH[3], 1'b0, 3);
    n_tests++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: valid=%b at t+3, want 0", bus.valid);
    end
    hold("single_d3", dsel(3), GLYPH[3], 1'b0, 1);
    n_tests++;
    if ({bus.valid, bus.err, bus.bcd} !== {1'b1, 4'b0000, 16'h3210}) begin
      n_fail++;
      $display("FAIL single_frame: got v=%b err=%b bcd=%h, want v=1 err=0000 bcd=3210",
               bus.valid, bus.err, bus.bcd);
    end
    hold("single_d3", dsel(3), GLYPH[3], 1'b0, 2);
    hold("single_acc", dsel(3), GLYPH[3], 1'b1, 1);
    n_tests++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: valid=%b after accept, want 0", bus.valid);
    end
  endtask

  task automatic test_short_strobe();
    logic [4*ND-1:0] v;
    v = rand_vals();
    hold("short", dsel(0), GLYPH[v[3:0]], 1'b0, 6);
    hold("short", dsel(1), GLYPH[v[7:4]], 1'b0, SC);
    send_digits("short", v, 2, 3, 1'b0);
    n_tests++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL short_no_frame: valid=%b with digit 1 held too briefly, want 0", bus.valid);
    end
    hold("short", dsel(1), GLYPH[v[7:4]], 1'b0, 6);
    n_tests++;
    if ({bus.valid, bus.bcd} !== {1'b1, v}) begin
      n_fail++;
      $display("FAIL short_frame: got v=%b bcd=%h, want v=1 bcd=%h", bus.valid, bus.bcd, v);
    end
    hold("short_acc", '0, '0, 1'b1, 1);
  endtask

  task automatic test_illegal_glyph();
    logic [4*ND-1:0] v;
    v = rand_vals();
    send_digits("illegal", v, 0, 1, 1'b0);
    hold("illegal", dsel(2), 7'b0000000, 1'b0, 6);
    hold("illegal", dsel(3), 7'b1110111, 1'b0, 6);
    n_tests++;
    if ({bus.valid, bus.err, bus.bcd} !== {1'b1, 4'b1100, 8'hFF, v[7:0]}) begin
      n_fail++;
      $display("FAIL illegal_frame: got v=%b err=%b bcd=%h, want v=1 err=1100 bcd=ff%h",
               bus.valid, bus.err, bus.bcd, v[7:0]);
    end
    hold("illegal_acc", '0, '0, 1'b1, 1);
  endtask

  task automatic test_backpressure();
    int ovr;
    send_digits("bp_a", 16'h8888, 0, 3, 1'b0);
    n_tests++;
    if ({bus.valid, bus.bcd} !== {1'b1, 16'h8888}) begin
      n_fail++;
      $display("FAIL bp_frame_a: got v=%b bcd=%h, want v=1 bcd=8888", bus.valid, bus.bcd);
    end
    send_digits("bp_b", 16'h5555, 0, 2, 1'b0);
    ovr = 0;
    for (int i = 0; i < 6; i++) begin
      hold("bp_b", dsel(3), GLYPH[5], 1'b0, 1);
      if (bus.overrun === 1'b1) ovr++;
    end
    n_tests++;
    if (ovr != 1) begin
      n_fail++;
      $display("FAIL bp_overrun: saw %0d overrun cycles, want 1", ovr);
    end
    n_tests++;
    if ({bus.valid, bus.bcd} !== {1'b1, 16'h8888}) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%b bcd=%h, want v=1 bcd=8888", bus.valid, bus.bcd);
    end
    hold("bp_acc", '0, '0, 1'b1, 1);
    n_tests++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: valid=%b after accept, want 0", bus.valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [4*ND-1:0] a;
    logic [4*ND-1:0] b;
    a = rand_vals();
    b = rand_vals();
    send_digits("b2b_a", a, 0, 3, 1'b0);
    send_digits("b2b_b", b, 0, 2, 1'b0);
    hold("b2b_b", dsel(3), GLYPH[b[15:12]], 1'b0, SC);
    hold("b2b_b", dsel(3), GLYPH[b[15:12]], 1'b1, 1);
    n_tests++;
    if ({bus.valid, bus.overrun, bus.bcd} !== {1'b1, 1'b0, b}) begin
      n_fail++;
      $display("FAIL b2b_load: got v=%b ov=%b bcd=%h, want v=1 ov=0 bcd=%h",
               bus.valid, bus.overrun, bus.bcd, b);
    end
    hold("b2b_acc", '0, '0, 1'b1, 1);
    n_tests++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: valid=%b after accept, want 0", bus.valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [4*ND-1:0] v;
    v = rand_vals();
    send_digits("rmid", 16'h7777, 0, 3, 1'b0);
    send_digits("rmid", v, 0, 1, 1'b0);
    tick(dsel(1), GLYPH[v[7:4]], 1'b0, 1'b1);
    n_tests++;
    if ({bus.valid, bus.overrun, bus.err, bus.bcd} !== '0) begin
      n_fail++;
      $display("FAIL rmid_outputs: got v=%b ov=%b err=%b bcd=%h, want all zero",
               bus.valid, bus.overrun, bus.err, bus.bcd);
    end
    send_digits("rmid", v, 2, 3, 1'b0);
    n_tests++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_partial: valid=%b with two digits after reset, want 0", bus.valid);
    end
    send_digits("rmid", v, 0, 1, 1'b0);
    n_tests++;
    if ({bus.valid, bus.bcd} !== {1'b1, v}) begin
      n_fail++;
      $display("FAIL rmid_frame: got v=%b bcd=%h, want v=1 bcd=%h", bus.valid, bus.bcd, v);
    end
    hold("rmid_acc", '0, '0, 1'b1, 1);
  endtask

  task automatic test_random();
    logic [ND-1:0] d;
    logic [6:0]    s;
    int            kind;
    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 8) begin
        d = dsel(int'($urandom_range(0, ND - 1)));
        s = ($urandom_range(0, 9) < 8) ? GLYPH[$urandom_range(0, 9)] : 7'($urandom);
      end else if (kind == 8) begin
        d = '0;
        s = 7'($urandom);
      end else begin
        d = ND'($urandom);
        if ($countones(d) < 2) d = ND'(3);
        s = 7'($urandom);
      end
      hold("random", d, s, 1'($urandom), int'($urandom_range(1, 7)));
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.segment = '0;
    bus.dig_en  = '0;
    bus.ready   = 1'b0;
    test_reset();
    test_single_frame();
    test_short_strobe();
    test_illegal_glyph();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Decodes a multiplexed, active-high seven-segment display bus back into packed BCD digits. It is the receiving end of our BCD-to-seven-segment path. The block samples the segment lines and the one-hot digit strobes, and waits for each digit's pattern to be stable before capturing it. Once every digit of a scan frame has been captured, it presents the whole frame through a valid/ready handshake. It sits between the display-drive pins (or a loopback of the display driver) and any consumer that needs the shown value, such as the self-test or readback logic.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits; must be ≥1.
- `STABLE_CYCLES`, 3: consecutive identical registered samples required before a capture; must be ≥1.
- `clk` input 1: sole clock; all logic is rising-edge.
- `rst` input 1: reset, synchronous and active-high.
- `segment` input 7: segment lines, bit0=a … bit6=g, active-high.
- `dig_en` input NUM_DIGITS: digit strobes; bit k high means `segment` currently shows digit k.
- `bcd` output 4*NUM_DIGITS: captured frame; digit k is at [4k+3:4k].
- `err` output NUM_DIGITS: bit k is set if digit k's pattern was not a legal 0–9 glyph.
- `valid` output 1: frame available in `bcd`/`err`.
- `ready` input 1: consumer accepts the frame when `valid && ready`.
- `overrun` output 1: one-cycle pulse when a completed frame is dropped.

## Operation
- **Decode table** (segment → bcd):
  - 7'b0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4
  - 1101101→5, 1111101→6, 0000111→7, 1111111→8, 1101111→9
  - Any other pattern, including blank 0000000, gives bcd 4'hF and sets the err bit.
- **Input stage:** `segment` and `dig_en` are registered every cycle into `s_seg`/`s_dig`.
- **Stability counter `cnt`:**
  - Width is clog2(STABLE_CYCLES+1).
  - Resets to 0 when `{s_dig,s_seg}` differs from the previous registered value, or when `s_dig` is not one-hot.
  - Otherwise increments, saturating at STABLE_CYCLES.
- **Capture:**
  - Occurs on the edge where `s_dig` is one-hot and `cnt == STABLE_CYCLES-1`.
  - Exactly one capture happens per stable episode; a saturated counter does not re-capture.
  - Capture writes the decoded nibble to slot k (where `s_dig[k]`=1), writes the err flag for slot k, and sets `mask[k]`.
  - If slot k is recaptured before the frame completes, it is overwritten; the latest value wins.
- **Frame complete:** when `mask | capture_bit` equals all ones:
  - If `valid`=0, or `valid && ready` in the same cycle: load `bcd`/`err` from the slots (including the slot being captured), set `valid`=1, and clear `mask`.
  - If `valid`=1 and `ready`=0: drop the frame, pulse `overrun`, clear `mask`, and leave `bcd`/`err`/`valid` unchanged.
- **Handshake:**
  - `bcd`, `err` and `valid` are held stable while `valid && !ready`.
  - `valid` clears on the edge after `valid && ready` unless a new frame loads on that same edge.
  - `ready` is ignored while `valid`=0.
- **Strobe gaps:** all-zero or multi-hot `dig_en` (blanking or ghosting) never captures and only restarts the counter.

## Timing
- **Reset:** `bcd`=0, `err`=0, `valid`=0, `overrun`=0, `mask`=0, `cnt`=0, `s_seg`=0, `s_dig`=0. Reset asserted mid-frame discards the partial frame and any pending output.
- **Capture latency:** input first presented in cycle t is registered in cycle t+1 with `cnt`=0. Capture occurs at the end of cycle t+STABLE_CYCLES.
- **Frame latency:** if that capture completes the frame, `valid` is high from cycle t+STABLE_CYCLES+1. With defaults, this is t+4.
- **Minimum hold:** a digit must be held for at least STABLE_CYCLES+1 input cycles to be captured. A change one cycle earlier yields no capture.
- **Throughput:** back-to-back frames can be accepted with `ready` tied high. `overrun` coincides with the edge at which the frame would have loaded.

## Test plan
- **Single frame:** reset, then hold each digit for 6 cycles, k=0..3 showing 0111111, 0000110, 1011011, 1001111. Expect `valid` four cycles after digit 3 is first presented, `bcd`=16'h3210, `err`=0.
- **Short strobe:** hold digit 1 for 3 cycles (less than STABLE_CYCLES+1), then move to digit 2. Expect no `mask[1]` and no frame until digit 1 is later held for ≥4 cycles.
- **Illegal glyph:** digit 2 shows 0000000 and digit 3 shows 1110111. Expect nibbles 4'hF at [11:8] and [15:12], and `err`=4'b1100.
- **Backpressure / overrun:** with `ready`=0, complete frame A (all 8s), then frame B (all 5s). Expect `bcd` to remain 16'h8888, a one-cycle `overrun` pulse, and after `ready`=1 one accept with `valid` then falling.
- **Accept and load on the same edge:** with `ready`=1 while the next frame completes. Expect `valid` to stay high and `bcd` to update to the new frame with no `overrun`.
- **Reset mid-frame:** assert `rst` after 2 digits have been captured. Expect all outputs 0, and after release the next frame requires all four digits before `valid`.
